// File: rtl/core_if_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_if_ifu_pkg
// Purpose  : Shared widths, reset constants, opcodes and immediate helpers
//            for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
package core_if_ifu_pkg;

  localparam int CORE_PC_WIDTH   = 32;
  localparam int CORE_INST_WIDTH = 32;
  localparam int CORE_IFQ_DEPTH  = 2;

  localparam logic [CORE_PC_WIDTH-1:0] CORE_RESET_PC   = 32'h8000_0000;
  localparam logic [6:0]               CORE_OPC_JAL    = 7'b1101111;
  localparam logic [6:0]               CORE_OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [CORE_PC_WIDTH-1:0]   pc;
    logic [CORE_INST_WIDTH-1:0] inst;
    logic                       pred;
  } ifq_entry_t;

  function automatic logic [CORE_PC_WIDTH-1:0] imm_j(input logic [CORE_INST_WIDTH-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [CORE_PC_WIDTH-1:0] imm_b(input logic [CORE_INST_WIDTH-1:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_if_predecode.sv
`default_nettype none
// ============================================================================
// Module   : core_if_predecode
// Purpose  : Combinational static predictor: JAL and backward branches taken.
// Revision : 1.0
// ============================================================================
module core_if_predecode
  import core_if_ifu_pkg::*;
(
  input  logic [CORE_INST_WIDTH-1:0] i_inst,
  input  logic [CORE_PC_WIDTH-1:0]   i_pc,
  output logic                       o_pred_taken,
  output logic [CORE_PC_WIDTH-1:0]   o_pred_target
);

  logic                     w_is_jal;
  logic                     w_is_branch;
  logic [CORE_PC_WIDTH-1:0] w_imm_j;
  logic [CORE_PC_WIDTH-1:0] w_imm_b;

  always_comb begin
    w_is_jal      = (i_inst[6:0] == CORE_OPC_JAL);
    w_is_branch   = (i_inst[6:0] == CORE_OPC_BRANCH);
    w_imm_j       = imm_j(i_inst);
    w_imm_b       = imm_b(i_inst);
    // The sign bit of the B-immediate marks a backward (loop) branch.
    o_pred_taken  = w_is_jal | (w_is_branch & w_imm_b[CORE_PC_WIDTH-1]);
    o_pred_target = w_is_jal ? (i_pc + w_imm_j) : (i_pc + w_imm_b);
  end

endmodule
`default_nettype wire

// File: rtl/core_if_ifu.sv
`default_nettype none
// ============================================================================
// Module   : core_if_ifu
// Purpose  : Fetch PC generation, credit-limited memory requests, static
//            prediction and a small decode-bound fetch queue.
// Revision : 1.0
// ============================================================================
module core_if_ifu
  import core_if_ifu_pkg::*;
#(
  parameter logic [CORE_PC_WIDTH-1:0] RESET_PC = CORE_RESET_PC,
  parameter int                       QDEPTH   = CORE_IFQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       o_req_valid,
  input  logic                       i_req_ready,
  output logic [CORE_PC_WIDTH-1:0]   o_req_addr,
  input  logic                       i_rsp_valid,
  input  logic [CORE_INST_WIDTH-1:0] i_rsp_inst,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [CORE_PC_WIDTH-1:0]   o_pc,
  output logic [CORE_INST_WIDTH-1:0] o_inst,
  output logic                       o_branch_predict,
  input  logic                       i_pipe_flush_req,
  input  logic [CORE_PC_WIDTH-1:0]   i_flush_pc
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(QDEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  logic [CORE_PC_WIDTH-1:0] r_fpc;
  logic [CW-1:0]            r_out_cnt;
  logic [CW-1:0]            r_drop_cnt;
  logic [CW-1:0]            r_q_cnt;
  logic [CORE_PC_WIDTH-1:0] r_if_pc [QDEPTH];
  logic [IW-1:0]            r_if_rptr;
  logic [IW-1:0]            r_if_wptr;
  ifq_entry_t               r_q [QDEPTH];
  logic [IW-1:0]            r_q_rptr;
  logic [IW-1:0]            r_q_wptr;

  logic                     w_credit;
  logic                     w_req_fire;
  logic [CORE_PC_WIDTH-1:0] w_rsp_pc;
  logic                     w_pred_taken;
  logic [CORE_PC_WIDTH-1:0] w_pred_target;
  logic                     w_rsp_keep;
  logic                     w_redir_pend;
  logic                     w_deq;
  logic [CW-1:0]            w_out_nxt;
  logic [CW-1:0]            w_drop_nxt;
  logic [CORE_PC_WIDTH-1:0] w_fpc_nxt;
  logic [CW-1:0]            w_q_cnt_nxt;

  assign w_rsp_pc = r_if_pc[r_if_rptr];

  core_if_predecode u_predecode (
    .i_inst        (i_rsp_inst),
    .i_pc          (w_rsp_pc),
    .o_pred_taken  (w_pred_taken),
    .o_pred_target (w_pred_target)
  );

  always_comb begin
    w_credit     = (({1'b0, r_out_cnt} + {1'b0, r_q_cnt}) < (CW + 1)'(QDEPTH));
    w_rsp_keep   = i_rsp_valid & (r_drop_cnt == '0) & ~i_pipe_flush_req;
    w_redir_pend = w_rsp_keep & w_pred_taken;
    o_req_valid  = w_credit & ~i_pipe_flush_req & ~w_redir_pend;
    o_req_addr   = r_fpc;
    w_req_fire   = o_req_valid & i_req_ready;

    valid_out        = (r_q_cnt != '0) & ~i_pipe_flush_req;
    o_pc             = r_q[r_q_rptr].pc;
    o_inst           = r_q[r_q_rptr].inst;
    o_branch_predict = r_q[r_q_rptr].pred;
    w_deq            = valid_out & ready_out;

    w_out_nxt = r_out_cnt + CW'(w_req_fire) - CW'(i_rsp_valid);

    // On flush or predicted redirect every request still outstanding after
    // this cycle belongs to the abandoned path, which is exactly w_out_nxt.
    w_drop_nxt = r_drop_cnt;
    if (i_pipe_flush_req || w_redir_pend) begin
      w_drop_nxt = w_out_nxt;
    end else if (i_rsp_valid && (r_drop_cnt != '0)) begin
      w_drop_nxt = r_drop_cnt - CW'(1);
    end

    w_fpc_nxt = r_fpc;
    if (i_pipe_flush_req) begin
      w_fpc_nxt = {i_flush_pc[CORE_PC_WIDTH-1:2], 2'b00};
    end else if (w_redir_pend) begin
      w_fpc_nxt = {w_pred_target[CORE_PC_WIDTH-1:2], 2'b00};
    end else if (w_req_fire) begin
      w_fpc_nxt = r_fpc + CORE_PC_WIDTH'(4);
    end

    w_q_cnt_nxt = r_q_cnt + CW'(w_rsp_keep) - CW'(w_deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc      <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_if_rptr  <= '0;
      r_if_wptr  <= '0;
      r_q_cnt    <= '0;
      r_q_rptr   <= '0;
      r_q_wptr   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_if_pc[i] <= '0;
        r_q[i]     <= '0;
      end
    end else begin
      r_fpc      <= w_fpc_nxt;
      r_out_cnt  <= w_out_nxt;
      r_drop_cnt <= w_drop_nxt;

      // In-flight PCs survive a flush: their responses still arrive in order.
      if (w_req_fire) begin
        r_if_pc[r_if_wptr] <= r_fpc;
        r_if_wptr          <= ptr_inc(r_if_wptr);
      end
      if (i_rsp_valid) begin
        r_if_rptr <= ptr_inc(r_if_rptr);
      end

      if (i_pipe_flush_req) begin
        r_q_cnt  <= '0;
        r_q_rptr <= '0;
        r_q_wptr <= '0;
      end else begin
        if (w_rsp_keep) begin
          r_q[r_q_wptr] <= '{pc: w_rsp_pc, inst: i_rsp_inst, pred: w_pred_taken};
          r_q_wptr      <= ptr_inc(r_q_wptr);
        end
        if (w_deq) begin
          r_q_rptr <= ptr_inc(r_q_rptr);
        end
        r_q_cnt <= w_q_cnt_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_if_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_if_ifu
// Purpose  : Random-stimulus scoreboard bench for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
module tb_core_if_ifu;
  import core_if_ifu_pkg::*;

  localparam int          QD   = 2;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam int          NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_req_valid;
  logic        i_req_ready;
  logic [31:0] o_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_inst;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_branch_predict;
  logic        i_pipe_flush_req;
  logic [31:0] i_flush_pc;

  core_if_ifu #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk              (clk),
    .rst              (rst),
    .o_req_valid      (o_req_valid),
    .i_req_ready      (i_req_ready),
    .o_req_addr       (o_req_addr),
    .i_rsp_valid      (i_rsp_valid),
    .i_rsp_inst       (i_rsp_inst),
    .valid_out        (valid_out),
    .ready_out        (ready_out),
    .o_pc             (o_pc),
    .o_inst           (o_inst),
    .o_branch_predict (o_branch_predict),
    .i_pipe_flush_req (i_pipe_flush_req),
    .i_flush_pc       (i_flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mq[$];
  exp_t        sb[$];
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_j(input int off);
    logic [20:0] imm;
    imm = off[20:0];
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input logic [2:0] f3);
    logic [12:0] imm;
    imm = off[12:0];
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Program image: each address maps to a fixed instruction with known control flow.
  function automatic void prog(input logic [31:0] a, output logic [31:0] inst,
                               output logic taken, output logic [31:0] tgt);
    logic [31:0] h;
    int          off;
    h     = (a >> 2) * 32'h9E37_79B1;
    h     = h ^ (h >> 13);
    taken = 1'b0;
    off   = 0;
    case (h[3:0])
      4'd9, 4'd10: begin off = (int'(h[9:4]) - 32) * 4; inst = enc_j(off); taken = 1'b1; end
      4'd11, 4'd12: begin off = -4 * (int'(h[7:4]) + 1); inst = enc_b(off, 3'b000); taken = 1'b1; end
      4'd13: begin off = 4 * (int'(h[7:4]) + 1); inst = enc_b(off, 3'b001); end
      4'd14: inst = {12'h010, 5'd1, 3'b000, 5'd0, 7'b1100111};
      default: inst = {h[31:20], 5'd0, 3'b000, 5'd0, 7'b0010011};
    endcase
    tgt = taken ? (a + 32'(off)) : (a + 32'd4);
  endfunction

  task automatic refill();
    logic [31:0] inst;
    logic [31:0] tgt;
    logic        tk;
    while (sb.size() < 8) begin
      prog(model_pc, inst, tk, tgt);
      sb.push_back('{pc: model_pc, inst: inst, pred: tk});
      model_pc = tgt;
    end
  endtask

  task automatic restart_model(input logic [31:0] pc);
    sb.delete();
    model_pc = pc;
    refill();
  endtask

  task automatic check_reset();
    chk("rst_req_valid", 96'(o_req_valid), 96'd1);
    chk("rst_req_addr", 96'(o_req_addr), 96'(RPC));
    chk("rst_valid_out", 96'(valid_out), 96'd0);
    chk("rst_payload", {31'd0, o_branch_predict, o_pc, o_inst}, 96'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    i_pipe_flush_req = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_inst = '0;
    i_req_ready = 1'b0;
    ready_out = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    restart_model(RPC);
    #1;
    check_reset();
  endtask

  // Monitor: pops the scoreboard on each decode handshake and checks stalls.
  logic        stall_prev = 1'b0;
  logic [64:0] stall_data;
  int          idle_cnt = 0;
  logic        timed_out = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      idle_cnt   = 0;
    end else begin
      if (i_pipe_flush_req) chk("valid_out_during_flush", 96'(valid_out), 96'd0);
      if (stall_prev && !i_pipe_flush_req)
        chk("stall_hold", {30'd0, valid_out, o_pc, o_inst, o_branch_predict}, {30'd0, 1'b1, stall_data});
      if (valid_out && ready_out) begin
        idle_cnt = 0;
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 96'd1, 96'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("deliver", {31'd0, o_pc, o_inst, o_branch_predict}, {31'd0, e.pc, e.inst, e.pred});
        end
      end else begin
        idle_cnt++;
        if (idle_cnt > 400 && !timed_out) begin
          timed_out = 1'b1;
          n_tests++;
          n_fail++;
          $display("FAIL progress_timeout: got %0d idle cycles expected at most 400", idle_cnt);
        end
      end
      stall_prev = valid_out && !ready_out;
      stall_data = {o_pc, o_inst, o_branch_predict};
    end
  end

  // Driver: random memory with in-order variable latency, backpressure and flushes.
  initial begin
    logic [31:0] a;
    logic [31:0] inst;
    logic [31:0] tgt;
    logic        tk;
    do_reset(3);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc == NCYC / 2) do_reset(2);
      refill();
      i_req_ready = ($urandom_range(0, 3) != 0);
      ready_out   = ((cyc % 200) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        a = mq.pop_front();
        prog(a, inst, tk, tgt);
        i_rsp_valid = 1'b1;
        i_rsp_inst  = inst;
      end else begin
        i_rsp_valid = 1'b0;
        i_rsp_inst  = '0;
      end
      i_pipe_flush_req = ($urandom_range(0, 39) == 0);
      i_flush_pc       = RPC + (32'($urandom_range(0, 1023)) << 2);
      if (i_pipe_flush_req) restart_model(i_flush_pc);
      #1;
      if (o_req_valid && i_req_ready) begin
        chk("req_aligned", 96'(o_req_addr[1:0]), 96'd0);
        mq.push_back(o_req_addr);
        chk("outstanding_bound", 96'(mq.size() <= QD), 96'd1);
      end
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
